// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: opcodes, ALU op encodings and the control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_RTYPE: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALUOP_FUNCT; end
      OP_LW:    begin c.alu_src = 1'b1; c.mem_to_reg = 1'b1; c.mem_read = 1'b1;
                      c.reg_write = 1'b1; c.alu_op = ALUOP_ADD; end
      OP_SW:    begin c.alu_src = 1'b1; c.mem_write = 1'b1; c.alu_op = ALUOP_ADD; end
      OP_BEQ:   begin c.branch = 1'b1; c.alu_op = ALUOP_SUB; end
      OP_ADDI:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALUOP_ADD; end
      OP_J:     c.jump = 1'b1;
      default:  c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 32x32 register file: two async read ports with same-cycle write-through, one sync write port.
// $0 is hardwired to zero; all registers clear on reset.
module reg_file (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  logic [31:0] r_regs [32];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Write-through lets WB feed ID in the same cycle without a stall.
  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 :
                    (i_we && (i_waddr == i_raddr1)) ? i_wdata : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 :
                    (i_we && (i_waddr == i_raddr2)) ? i_wdata : r_regs[i_raddr2];

endmodule

// File: rtl/id_stage.sv
// Decode stage plus ID/EX register; latency 1. Load-use hazards raise a combinational Stall
// and inject one bubble; Flush kills the instruction entering EX.
module id_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC_ADD4 = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IFtoID_PCadd4,
  input  logic [31:0] IFtoID_Instr,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_WriteReg,
  input  logic [31:0] WB_WriteData,
  input  logic        Flush,
  output logic        Stall,
  output logic [31:0] IDtoEX_PCadd4,
  output logic [31:0] IDtoEX_ReadData1,
  output logic [31:0] IDtoEX_ReadData2,
  output logic [31:0] IDtoEX_Imm,
  output logic [4:0]  IDtoEX_Rs,
  output logic [4:0]  IDtoEX_Rt,
  output logic [4:0]  IDtoEX_Rd,
  output logic [5:0]  IDtoEX_funct,
  output logic [25:0] IDtoEX_j_address,
  output logic [1:0]  IDtoEX_ALUop,
  output logic        IDtoEX_ALUSrc,
  output logic        IDtoEX_RegDst,
  output logic        IDtoEX_MemRead,
  output logic        IDtoEX_MemWrite,
  output logic        IDtoEX_MemtoReg,
  output logic        IDtoEX_RegWrite,
  output logic        IDtoEX_Branch,
  output logic        IDtoEX_Jump
);

  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_imm, w_rdata1, w_rdata2;
  logic        w_unused_shamt;
  ctrl_t       w_ctrl;

  logic [31:0] r_pcadd4, r_rdata1, r_rdata2, r_imm;
  logic [4:0]  r_rs, r_rt, r_rd;
  logic [5:0]  r_funct;
  logic [25:0] r_jaddr;
  ctrl_t       r_ctrl;

  assign w_rs           = IFtoID_Instr[25:21];
  assign w_rt           = IFtoID_Instr[20:16];
  assign w_rd           = IFtoID_Instr[15:11];
  assign w_imm          = {{16{IFtoID_Instr[15]}}, IFtoID_Instr[15:0]};
  assign w_ctrl         = decode_ctrl(IFtoID_Instr[31:26]);
  assign w_unused_shamt = ^IFtoID_Instr[10:6];

  reg_file u_reg_file (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2),
    .i_we     (WB_RegWrite),
    .i_waddr  (WB_WriteReg),
    .i_wdata  (WB_WriteData)
  );

  // Rt is compared even for formats that don't read it; a spurious stall costs one cycle only.
  assign Stall = r_ctrl.mem_read && (r_rt != 5'd0) && ((r_rt == w_rs) || (r_rt == w_rt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcadd4 <= RESET_PC_ADD4;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_funct  <= '0;
      r_jaddr  <= '0;
      r_ctrl   <= CTRL_NOP;
    end else begin
      r_pcadd4 <= IFtoID_PCadd4;
      r_rdata1 <= w_rdata1;
      r_rdata2 <= w_rdata2;
      r_imm    <= w_imm;
      r_rs     <= w_rs;
      r_rt     <= w_rt;
      r_rd     <= w_rd;
      r_funct  <= IFtoID_Instr[5:0];
      r_jaddr  <= IFtoID_Instr[25:0];
      r_ctrl   <= (Flush || Stall) ? CTRL_NOP : w_ctrl;
    end
  end

  assign IDtoEX_PCadd4    = r_pcadd4;
  assign IDtoEX_ReadData1 = r_rdata1;
  assign IDtoEX_ReadData2 = r_rdata2;
  assign IDtoEX_Imm       = r_imm;
  assign IDtoEX_Rs        = r_rs;
  assign IDtoEX_Rt        = r_rt;
  assign IDtoEX_Rd        = r_rd;
  assign IDtoEX_funct     = r_funct;
  assign IDtoEX_j_address = r_jaddr;
  assign IDtoEX_ALUop     = r_ctrl.alu_op;
  assign IDtoEX_ALUSrc    = r_ctrl.alu_src;
  assign IDtoEX_RegDst    = r_ctrl.reg_dst;
  assign IDtoEX_MemRead   = r_ctrl.mem_read;
  assign IDtoEX_MemWrite  = r_ctrl.mem_write;
  assign IDtoEX_MemtoReg  = r_ctrl.mem_to_reg;
  assign IDtoEX_RegWrite  = r_ctrl.reg_write;
  assign IDtoEX_Branch    = r_ctrl.branch;
  assign IDtoEX_Jump      = r_ctrl.jump;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a reference model pushes the expected ID/EX bundle when
// an instruction is driven; it is popped and compared one edge later.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IFtoID_PCadd4, IFtoID_Instr;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_WriteData;
  logic        Flush;
  logic        Stall;
  logic [31:0] IDtoEX_PCadd4, IDtoEX_ReadData1, IDtoEX_ReadData2, IDtoEX_Imm;
  logic [4:0]  IDtoEX_Rs, IDtoEX_Rt, IDtoEX_Rd;
  logic [5:0]  IDtoEX_funct;
  logic [25:0] IDtoEX_j_address;
  logic [1:0]  IDtoEX_ALUop;
  logic IDtoEX_ALUSrc, IDtoEX_RegDst, IDtoEX_MemRead, IDtoEX_MemWrite;
  logic IDtoEX_MemtoReg, IDtoEX_RegWrite, IDtoEX_Branch, IDtoEX_Jump;

  always #5 clk = ~clk;

  id_stage #(.RESET_PC_ADD4(32'h0000_0004)) dut (
    .clk(clk), .rst(rst),
    .IFtoID_PCadd4(IFtoID_PCadd4), .IFtoID_Instr(IFtoID_Instr),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
    .Flush(Flush), .Stall(Stall),
    .IDtoEX_PCadd4(IDtoEX_PCadd4), .IDtoEX_ReadData1(IDtoEX_ReadData1),
    .IDtoEX_ReadData2(IDtoEX_ReadData2), .IDtoEX_Imm(IDtoEX_Imm),
    .IDtoEX_Rs(IDtoEX_Rs), .IDtoEX_Rt(IDtoEX_Rt), .IDtoEX_Rd(IDtoEX_Rd),
    .IDtoEX_funct(IDtoEX_funct), .IDtoEX_j_address(IDtoEX_j_address),
    .IDtoEX_ALUop(IDtoEX_ALUop), .IDtoEX_ALUSrc(IDtoEX_ALUSrc), .IDtoEX_RegDst(IDtoEX_RegDst),
    .IDtoEX_MemRead(IDtoEX_MemRead), .IDtoEX_MemWrite(IDtoEX_MemWrite),
    .IDtoEX_MemtoReg(IDtoEX_MemtoReg), .IDtoEX_RegWrite(IDtoEX_RegWrite),
    .IDtoEX_Branch(IDtoEX_Branch), .IDtoEX_Jump(IDtoEX_Jump)
  );

  typedef struct packed {
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [25:0] ja;
    logic [1:0]  aluop;
    logic alusrc, regdst, memread, memwrite, memtoreg, regwrite, branch, jump;
  } bundle_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_regs [32];
  bundle_t     m_ex;
  bundle_t     q [$];

  function automatic bundle_t reset_bundle();
    bundle_t b;
    b = '0;
    b.pc = 32'h0000_0004;
    return b;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (WB_RegWrite && WB_WriteReg == a) return WB_WriteData;
    return m_regs[a];
  endfunction

  function automatic logic m_stall(input logic [31:0] instr);
    return m_ex.memread && (m_ex.rt != 5'd0) &&
           ((m_ex.rt == instr[25:21]) || (m_ex.rt == instr[20:16]));
  endfunction

  function automatic bundle_t model(input logic [31:0] pc, input logic [31:0] instr,
                                    input logic fl);
    bundle_t e;
    e = '0;
    e.pc = pc;  e.rs = instr[25:21];  e.rt = instr[20:16];  e.rd = instr[15:11];
    e.funct = instr[5:0];  e.ja = instr[25:0];
    e.imm = {{16{instr[15]}}, instr[15:0]};
    e.rd1 = m_read(instr[25:21]);
    e.rd2 = m_read(instr[20:16]);
    if (!fl && !m_stall(instr)) begin
      case (instr[31:26])
        6'h00: begin e.regdst = 1; e.regwrite = 1; e.aluop = 2'b10; end
        6'h23: begin e.alusrc = 1; e.memtoreg = 1; e.memread = 1; e.regwrite = 1; end
        6'h2B: begin e.alusrc = 1; e.memwrite = 1; end
        6'h04: begin e.branch = 1; e.aluop = 2'b01; end
        6'h08: begin e.alusrc = 1; e.regwrite = 1; end
        6'h02: e.jump = 1;
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic bundle_t observe();
    bundle_t o;
    o = {IDtoEX_PCadd4, IDtoEX_ReadData1, IDtoEX_ReadData2, IDtoEX_Imm,
         IDtoEX_Rs, IDtoEX_Rt, IDtoEX_Rd, IDtoEX_funct, IDtoEX_j_address, IDtoEX_ALUop,
         IDtoEX_ALUSrc, IDtoEX_RegDst, IDtoEX_MemRead, IDtoEX_MemWrite,
         IDtoEX_MemtoReg, IDtoEX_RegWrite, IDtoEX_Branch, IDtoEX_Jump};
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input bundle_t obs, input bundle_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one instruction (and optional WB write) in ID and queue its expected ID/EX result.
  task automatic drive(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic fl);
    @(negedge clk);
    IFtoID_PCadd4 = pc;  IFtoID_Instr = instr;
    WB_RegWrite = we;  WB_WriteReg = wr;  WB_WriteData = wd;  Flush = fl;
    #1;
    chk({tag, "_stall"}, {63'd0, Stall}, {63'd0, m_stall(instr)});
    q.push_back(model(pc, instr, fl));
  endtask

  task automatic commit(input string tag);
    bundle_t e;
    @(posedge clk);
    if (WB_RegWrite && WB_WriteReg != 5'd0) m_regs[WB_WriteReg] = WB_WriteData;
    #1;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = q.pop_front();
      m_ex = e;
      chk_b(tag, observe(), e);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_ex = reset_bundle();
    rst = 1'b1;  Flush = 1'b0;
    IFtoID_PCadd4 = '0;  IFtoID_Instr = '0;
    WB_RegWrite = 1'b0;  WB_WriteReg = '0;  WB_WriteData = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_b("reset_bundle", observe(), reset_bundle());
    chk("reset_stall", {63'd0, Stall}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // add $9,$8,$0 with WB writing $8 in the same cycle
    drive("add_wt", 32'h100, 32'h0100_4820, 1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0);
    commit("add_wt");
    chk("add_rd1", {32'd0, IDtoEX_ReadData1}, {32'd0, 32'hDEAD_BEEF});
    chk("add_ctl", {58'd0, IDtoEX_RegDst, IDtoEX_RegWrite, IDtoEX_ALUop, IDtoEX_ALUSrc, IDtoEX_MemRead},
        {58'd0, 6'b111000});
    chk("add_funct", {58'd0, IDtoEX_funct}, {58'd0, 6'h20});

    // lw $2,-4($3), then dependent add $4,$2,$5
    drive("lw", 32'h104, 32'h8C62_FFFC, 1'b1, 5'd3, 32'h0000_0100, 1'b0);
    commit("lw");
    chk("lw_imm", {32'd0, IDtoEX_Imm}, {32'd0, 32'hFFFF_FFFC});
    chk("lw_ctl", {59'd0, IDtoEX_ALUSrc, IDtoEX_MemRead, IDtoEX_MemtoReg, IDtoEX_RegWrite, IDtoEX_MemWrite},
        {59'd0, 5'b11110});
    chk("lw_rt", {59'd0, IDtoEX_Rt}, 64'd2);
    drive("luse", 32'h108, 32'h0045_2020, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("luse_stall1", {63'd0, Stall}, 64'd1);
    commit("luse_bubble");
    chk("luse_bubble_ctl", {54'd0, IDtoEX_ALUop, IDtoEX_RegWrite, IDtoEX_RegDst, IDtoEX_MemRead,
        IDtoEX_MemWrite, IDtoEX_MemtoReg, IDtoEX_ALUSrc, IDtoEX_Branch, IDtoEX_Jump}, 64'd0);
    chk("luse_stall_drop", {63'd0, Stall}, 64'd0);
    drive("luse_issue", 32'h108, 32'h0045_2020, 1'b0, 5'd0, 32'd0, 1'b0);
    commit("luse_issue");
    chk("luse_issue_rw", {63'd0, IDtoEX_RegWrite}, 64'd1);

    // writes to $0 are dropped; lw $0 never stalls
    drive("r0_wr", 32'h10C, 32'h0000_0820, 1'b1, 5'd0, 32'h0000_1234, 1'b0);
    commit("r0_wr");
    chk("r0_rd1", {32'd0, IDtoEX_ReadData1}, 64'd0);
    drive("lw_r0", 32'h110, 32'h8C20_0000, 1'b0, 5'd0, 32'd0, 1'b0);
    commit("lw_r0");
    drive("use_r0", 32'h114, 32'h0000_3020, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("use_r0_stall", {63'd0, Stall}, 64'd0);
    commit("use_r0");

    // flush kills beq; then an unflushed beq
    drive("beq_fl", 32'h118, 32'h1085_0003, 1'b0, 5'd0, 32'd0, 1'b1);
    commit("beq_fl");
    chk("beq_fl_branch", {63'd0, IDtoEX_Branch}, 64'd0);
    drive("beq", 32'h11C, 32'h1085_0003, 1'b0, 5'd0, 32'd0, 1'b0);
    commit("beq");
    chk("beq_ctl", {61'd0, IDtoEX_Branch, IDtoEX_ALUop}, {61'd0, 3'b101});

    // flush coinciding with a load-use stall
    drive("lw7", 32'h120, 32'h8C07_0000, 1'b0, 5'd0, 32'd0, 1'b0);
    commit("lw7");
    drive("fl_stall", 32'h124, 32'h00E7_4020, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("fl_stall_stall", {63'd0, Stall}, 64'd1);
    commit("fl_stall");
    chk("fl_stall_ctl", {62'd0, IDtoEX_RegWrite, IDtoEX_MemRead}, 64'd0);
    drive("fl_stall_issue", 32'h124, 32'h00E7_4020, 1'b0, 5'd0, 32'd0, 1'b0);
    commit("fl_stall_issue");

    // unknown opcode, jump, sw, addi
    drive("op3f", 32'h128, 32'hFC00_0000, 1'b0, 5'd0, 32'd0, 1'b0);
    commit("op3f");
    drive("j", 32'h12C, 32'h0800_0010, 1'b0, 5'd0, 32'd0, 1'b0);
    commit("j");
    chk("j_ctl", {37'd0, IDtoEX_Jump, IDtoEX_j_address}, {37'd0, 1'b1, 26'h10});
    drive("sw", 32'h130, 32'hAC65_0008, 1'b0, 5'd0, 32'd0, 1'b0);
    commit("sw");
    drive("addi", 32'h134, 32'h2041_FFFF, 1'b0, 5'd0, 32'd0, 1'b0);
    commit("addi");

    // asynchronous reset while a load-use stall is pending
    drive("lw9", 32'h138, 32'h8C09_0000, 1'b1, 5'd5, 32'h0000_0055, 1'b0);
    commit("lw9");
    drive("use9", 32'h13C, 32'h0009_5020, 1'b0, 5'd0, 32'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_b("midreset_bundle", observe(), reset_bundle());
    chk("midreset_stall", {63'd0, Stall}, 64'd0);
    q.delete();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_ex = reset_bundle();
    @(negedge clk);
    rst = 1'b0;
    drive("rd5", 32'h200, 32'h00A0_0020, 1'b0, 5'd0, 32'd0, 1'b0);
    commit("rd5");
    chk("rd5_zero", {32'd0, IDtoEX_ReadData1}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
